// File: rtl/gen_nonlinear_part_seq_pkg.sv
// Shared constants for the decomposed CLA adder: adder width, width of the
// non-linear term vector, per-level segment placement and the FSM states.
// Ports: none (package).
package gen_nonlinear_part_seq_pkg;

    localparam int NBIT = 7;
    localparam int NNL  = 2 ** (NBIT + 2) - NBIT - 4;
    // Level counter holds 0..NBIT.
    localparam int KW   = $clog2(NBIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of AND products that make up the carry into bit i.
    function automatic int seg_len(input int i);
        return 2 ** (i + 1) - 1;
    endfunction

    // Start of level i inside n; levels are packed back to back from level 1.
    function automatic int seg_off(input int i);
        return 2 ** (i + 1) - i - 3;
    endfunction

    // Level whose segment contains bit i of n (0 if outside every segment).
    function automatic int seg_lvl(input int i);
        int r;
        r = 0;
        for (int l = NBIT; l >= 1; l--)
            if (i < seg_off(l) + seg_len(l))
                r = l;
        return r;
    endfunction

endpackage

// File: rtl/gen_nonlinear_part_seq_if.sv
// Operand/result handshake bundle between the producer of an operand pair,
// the non-linear term generator and its downstream consumer.
// Signals: a, b, c_in, in_valid -> generator; in_ready <- generator;
//          n, a_q, b_q, out_valid <- generator; out_ready -> generator.
// Modports: master = the bench/producer side, slave = the generator.
interface gen_nonlinear_part_seq_if;
    import gen_nonlinear_part_seq_pkg::*;

    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            c_in;
    logic            in_valid;
    logic            in_ready;
    logic [NNL-1:0]  n;
    logic [NBIT-1:0] a_q;
    logic [NBIT-1:0] b_q;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output a, b, c_in, in_valid, out_ready,
        input  in_ready, n, a_q, b_q, out_valid
    );

    modport slave (
        input  a, b, c_in, in_valid, out_ready,
        output in_ready, n, a_q, b_q, out_valid
    );

endinterface

// File: rtl/gen_nonlinear_part_seq_nl_level.sv
// Combinational builder of one carry level: from the products of level
// LVL-1 it forms the products of level LVL.
// Ports: a_bit, b_bit - operand bits LVL-1; prev - level LVL-1 products;
//        cur - level LVL products, ordered [a&b, a&prev[j]..., b&prev[j]...].
module gen_nonlinear_part_seq_nl_level #(
    parameter int LVL = 1
) (
    input  logic                     a_bit,
    input  logic                     b_bit,
    input  logic [2**LVL-2:0]        prev,
    output logic [2**(LVL+1)-2:0]    cur
);
    localparam int PW = 2 ** LVL - 1;

    // Generate term first, then a-propagated then b-propagated copies of
    // the previous level; the XOR over cur is the carry into bit LVL.
    assign cur = {({PW{b_bit}} & prev), ({PW{a_bit}} & prev), (a_bit & b_bit)};

endmodule

// File: rtl/gen_nonlinear_part_seq.sv
// Sequential generator of the non-linear carry products n for the
// decomposed CLA adder. Accepts one operand pair, then writes one carry
// level per clock into n, and presents n with the latched operands until
// the consumer takes them.
// Ports: clk - rising-edge clock; rst - synchronous active-high reset;
//        bus - handshake bundle (slave side): a/b/c_in/in_valid/in_ready in,
//              n/a_q/b_q/out_valid/out_ready out.
module gen_nonlinear_part_seq
    import gen_nonlinear_part_seq_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    gen_nonlinear_part_seq_if.slave  bus
);

    state_t          state;
    logic [KW-1:0]   k;
    logic [NBIT-1:0] a_r;
    logic [NBIT-1:0] b_r;
    logic            cin_r;
    logic [NNL-1:0]  n_r;
    logic            in_ready_r;
    logic            out_valid_r;

    // Every level computed from the registered previous level; only the
    // level selected by k is actually stored each cycle.
    logic [NNL-1:0]  n_all;
    logic [NNL-1:0]  wr_en;

    for (genvar g = 1; g <= NBIT; g++) begin : g_lvl
        localparam int OFF = seg_off(g);
        localparam int LEN = seg_len(g);
        localparam int PW  = 2 ** g - 1;

        logic [PW-1:0]  prev;
        logic [LEN-1:0] cur;

        if (g == 1) begin : g_first
            assign prev = cin_r;
        end else begin : g_rest
            assign prev = n_r[seg_off(g-1) +: PW];
        end

        gen_nonlinear_part_seq_nl_level #(.LVL(g)) u_level (
            .a_bit (a_r[g-1]),
            .b_bit (b_r[g-1]),
            .prev  (prev),
            .cur   (cur)
        );

        assign n_all[OFF +: LEN] = cur;
    end

    // Per-bit write enable: a bit is rewritten only in the cycle its own
    // level is being built, so no segment ever touches another's range.
    for (genvar i = 0; i < NNL; i++) begin : g_bit
        localparam int L = seg_lvl(i);
        assign wr_en[i] = (state == ST_BUILD) && (k == KW'(L));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            k           <= '0;
            a_r         <= '0;
            b_r         <= '0;
            cin_r       <= 1'b0;
            n_r         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            n_r <= (n_r & ~wr_en) | (n_all & wr_en);
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        cin_r      <= bus.c_in;
                        k          <= KW'(1);
                        state      <= ST_BUILD;
                        in_ready_r <= 1'b0;
                    end
                end
                ST_BUILD: begin
                    // Level NBIT is stored on this edge; result complete.
                    if (k == KW'(NBIT)) begin
                        state       <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        k           <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    k           <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.n         = n_r;
    assign bus.a_q       = a_r;
    assign bus.b_q       = b_r;

endmodule

// File: tb/tb_gen_nonlinear_part_seq.sv
// Directed and random checks for gen_nonlinear_part_seq: reset state,
// hand-computed term vectors, handshake latency, back-pressure, reset
// during the build and agreement of the carries with integer addition.
module tb_gen_nonlinear_part_seq;
    import gen_nonlinear_part_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gen_nonlinear_part_seq_if bus ();

    gen_nonlinear_part_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Product j of level i, walked down the term-list definition.
    function automatic bit term(input int lvl, input int idx, input logic [NBIT-1:0] a,
                                input logic [NBIT-1:0] b, input bit cin);
        bit v;
        bit done;
        int i;
        int j;
        int pl;
        v = 1'b1; done = 1'b0; i = lvl; j = idx;
        while (i > 0 && !done) begin
            if (j == 0) begin
                v = v & a[i-1] & b[i-1];
                done = 1'b1;
            end else begin
                pl = (1 << i) - 1;
                if (j <= pl) begin
                    v = v & a[i-1]; j = j - 1;
                end else begin
                    v = v & b[i-1]; j = j - 1 - pl;
                end
                i--;
            end
        end
        if (!done) v = v & cin;
        return v;
    endfunction

    function automatic logic [NNL-1:0] ref_n(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                             input bit cin);
        logic [NNL-1:0] r;
        r = '0;
        for (int i = 1; i <= NBIT; i++)
            for (int j = 0; j < (1 << (i + 1)) - 1; j++)
                r[(1 << (i + 1)) - i - 3 + j] = term(i, j, a, b, cin);
        return r;
    endfunction

    function automatic bit seg_xor(input logic [NNL-1:0] nv, input int i);
        bit x;
        x = 1'b0;
        for (int j = 0; j < (1 << (i + 1)) - 1; j++)
            x ^= nv[(1 << (i + 1)) - i - 3 + j];
        return x;
    endfunction

    // Sum as the downstream linear stage forms it (carry-in omitted at bit 0).
    function automatic logic [NBIT-1:0] sum_of(input logic [NNL-1:0] nv, input logic [NBIT-1:0] a,
                                               input logic [NBIT-1:0] b);
        logic [NBIT-1:0] s;
        s[0] = a[0] ^ b[0];
        for (int i = 1; i < NBIT; i++)
            s[i] = a[i] ^ b[i] ^ seg_xor(nv, i);
        return s;
    endfunction

    task automatic send(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic cin);
        int t;
        t = 0;
        while (!bus.in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 512'(bus.in_ready), 512'(1));
        bus.a = a; bus.b = b; bus.c_in = cin; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 512'(lat), 512'(NBIT));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NNL-1:0]  hm;
        logic [NNL-1:0]  exp_n;
        logic [NBIT-1:0] ra;
        logic [NBIT-1:0] rb;
        logic [NBIT-1:0] rsum;
        int              hand_idx [7] = '{0, 4, 12, 28, 60, 124, 252};
        bit              seen;

        bus.a = '0; bus.b = '0; bus.c_in = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready",  512'(bus.in_ready),  512'(1));
        check("rst_out_valid", 512'(bus.out_valid), 512'(0));
        check("rst_n",         512'(bus.n),         512'(0));
        check("rst_a_q",       512'(bus.a_q),       512'(0));
        check("rst_b_q",       512'(bus.b_q),       512'(0));

        // 1 + 1: only the bit-0 generate term is set.
        send(7'h01, 7'h01, 1'b0);
        check("busy_in_ready",  512'(bus.in_ready),  512'(0));
        check("busy_out_valid", 512'(bus.out_valid), 512'(0));
        wait_done("p11");
        check("p11_n",   512'(bus.n),   512'(1));
        check("p11_s",   512'(sum_of(bus.n, 7'h01, 7'h01)), 512'(7'h02));
        check("p11_a_q", 512'(bus.a_q), 512'(7'h01));
        check("p11_b_q", 512'(bus.b_q), 512'(7'h01));
        consume();
        check("p11_free_in_ready",  512'(bus.in_ready),  512'(1));
        check("p11_free_out_valid", 512'(bus.out_valid), 512'(0));

        // 0x7F + 0x01: the carry ripples through every level via a-chains.
        send(7'h7F, 7'h01, 1'b0);
        wait_done("p7f");
        hm = '0;
        foreach (hand_idx[i]) hm[hand_idx[i]] = 1'b1;
        check("p7f_n", 512'(bus.n), 512'(hm));
        check("p7f_s", 512'(sum_of(bus.n, 7'h7F, 7'h01)), 512'(7'h00));
        for (int i = 1; i <= NBIT; i++)
            check($sformatf("p7f_carry%0d", i), 512'(seg_xor(bus.n, i)), 512'(1));
        consume();

        // Carry-in only reaches n through level 1.
        send(7'h00, 7'h00, 1'b1);
        wait_done("cin0");
        check("cin0_n", 512'(bus.n), 512'(0));
        consume();
        send(7'h01, 7'h00, 1'b1);
        wait_done("cin1");
        check("cin1_n",      512'(bus.n), 512'(2));
        check("cin1_carry1", 512'(seg_xor(bus.n, 1)), 512'(1));
        consume();

        // Back-pressure with a competing operand pair held on the input.
        send(7'h55, 7'h2A, 1'b0);
        wait_done("bp");
        exp_n = ref_n(7'h55, 7'h2A, 1'b0);
        bus.a = 7'h33; bus.b = 7'h44; bus.c_in = 1'b1; bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check("bp_n",         512'(bus.n),         512'(exp_n));
            check("bp_a_q",       512'(bus.a_q),       512'(7'h55));
            check("bp_b_q",       512'(bus.b_q),       512'(7'h2A));
            check("bp_in_ready",  512'(bus.in_ready),  512'(0));
            check("bp_out_valid", 512'(bus.out_valid), 512'(1));
            @(negedge clk);
        end
        bus.a = 7'h11; bus.b = 7'h22; bus.c_in = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_rel_in_ready",  512'(bus.in_ready),  512'(1));
        check("bp_rel_out_valid", 512'(bus.out_valid), 512'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_accept_in_ready", 512'(bus.in_ready), 512'(0));
        wait_done("bp2");
        check("bp2_n",   512'(bus.n),   512'(ref_n(7'h11, 7'h22, 1'b0)));
        check("bp2_a_q", 512'(bus.a_q), 512'(7'h11));
        consume();

        // Reset while level 3 is about to be written.
        send(7'h0F, 7'h0F, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready",  512'(bus.in_ready),  512'(1));
        check("abort_out_valid", 512'(bus.out_valid), 512'(0));
        check("abort_n",         512'(bus.n),         512'(0));
        check("abort_a_q",       512'(bus.a_q),       512'(0));
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_valid", 512'(seen), 512'(0));

        // Random pairs against integer addition and the term model.
        for (int r = 0; r < 1000; r++) begin
            ra = 7'($urandom_range(0, 127));
            rb = 7'($urandom_range(0, 127));
            rsum = ra + rb;
            send(ra, rb, 1'b0);
            wait_done("rand");
            check("rand_s", 512'(sum_of(bus.n, ra, rb)), 512'(rsum));
            check("rand_n", 512'(bus.n), 512'(ref_n(ra, rb, 1'b0)));
            consume();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
